qchan_lp_buffer: RTL and testbench

QCHAN_LP_BUFFER -- requirements
Module: qchan_lp_buffer

---
 rtl/qchan_lp_buffer_pkg.sv | 7 +
 rtl/qchan_lp_buffer_if.sv | 27 ++
 rtl/qchan_lp_buffer_fifo.sv | 43 ++++
 rtl/qchan_lp_buffer.sv | 70 +++++++
 tb/tb_qchan_lp_buffer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/qchan_lp_buffer_pkg.sv
// qchan_lp_pkg: shared state encoding and parameter defaults for the Q-channel low-power buffer
package qchan_lp_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_N_CH = 2;
  typedef enum logic [2:0] {RUN, FLUSH, DRAIN, STOPPED, DENIED} lp_state_e;
endpackage

// File: rtl/qchan_lp_buffer_if.sv
// qchan_lp_buffer_if: push/pop, flush handshake and Q-channel signals of the low-power buffer
interface qchan_lp_buffer_if import qchan_lp_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_CH = DEF_N_CH
);
  logic if_wakeup_i;
  logic [N_CH-1:0] wr_valid_i;
  logic [N_CH*DATA_W-1:0] wr_payload_i;
  logic [N_CH-1:0] wr_full_o;
  logic [N_CH-1:0] wr_flush_o;
  logic [N_CH-1:0] wr_done_i;
  logic [N_CH-1:0] rd_valid_i;
  logic [N_CH*DATA_W-1:0] rd_payload_o;
  logic [N_CH-1:0] rd_empty_o;
  logic qreqn_i;
  logic qacceptn_o;
  logic qdeny_o;
  logic qactive_o;
  modport master (
    output if_wakeup_i, wr_valid_i, wr_payload_i, wr_done_i, rd_valid_i, qreqn_i,
    input wr_full_o, wr_flush_o, rd_payload_o, rd_empty_o, qacceptn_o, qdeny_o, qactive_o
  );
  modport slave (
    input if_wakeup_i, wr_valid_i, wr_payload_i, wr_done_i, rd_valid_i, qreqn_i,
    output wr_full_o, wr_flush_o, rd_payload_o, rd_empty_o, qacceptn_o, qdeny_o, qactive_o
  );
endinterface

// File: rtl/qchan_lp_buffer_fifo.sv
// lpb_fifo: first-word-fall-through FIFO with occupancy counter and non-power-of-2 pointer wrap
module lpb_fifo import qchan_lp_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic w_push, w_pop;
  assign o_empty = r_cnt == '0;
  assign o_full = r_cnt == CNT_W'(DEPTH);
  assign w_pop = i_pop && !o_empty;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign w_push = i_push && (!o_full || w_pop);
  assign o_data = r_mem[r_rd_ptr];
  // pointer and occupancy bookkeeping; reset discards all buffered data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end
  // storage needs no reset: entries are only visible once counted
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

// File: rtl/qchan_lp_buffer.sv
// qchan_lp_buffer: per-channel FIFOs gated by a Q-channel flush/drain/stop handshake
module qchan_lp_buffer import qchan_lp_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int N_CH = DEF_N_CH
) (
  input logic clk,
  input logic reset,
  qchan_lp_buffer_if.slave bus
);
  lp_state_e r_state, w_next;
  logic [N_CH-1:0] r_done_q, w_done_next, w_empty, w_full, w_push, w_pop;
  logic [N_CH*DATA_W-1:0] w_rd_payload;
  logic w_push_en, w_pop_en, w_any;
  assign w_push_en = r_state == RUN || r_state == FLUSH;
  assign w_pop_en = r_state != STOPPED;
  assign w_push = bus.wr_valid_i & {N_CH{w_push_en}};
  assign w_pop = bus.rd_valid_i & {N_CH{w_pop_en}};
  assign w_any = !(&w_empty);
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    lpb_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .reset(reset),
      .i_push(w_push[g]),
      .i_pop(w_pop[g]),
      .i_data(bus.wr_payload_i[g*DATA_W +: DATA_W]),
      .o_data(w_rd_payload[g*DATA_W +: DATA_W]),
      .o_full(w_full[g]),
      .o_empty(w_empty[g])
    );
  end
  // state register and sticky per-channel flush-done flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_done_q <= '0;
    end else begin
      r_state <= w_next;
      r_done_q <= w_done_next;
    end
  end
  // next-state: wakeup during flush/drain aborts to DENIED ahead of progress
  always_comb begin
    w_next = r_state;
    w_done_next = r_done_q;
    case (r_state)
      RUN: if (!bus.qreqn_i) begin
        w_next = FLUSH;
        w_done_next = '0;
      end
      FLUSH: begin
        w_done_next = r_done_q | bus.wr_done_i;
        if (bus.if_wakeup_i) w_next = DENIED;
        else if (&w_done_next) w_next = DRAIN;
      end
      DRAIN: if (bus.if_wakeup_i) w_next = DENIED;
        else if (!w_any) w_next = STOPPED;
      STOPPED, DENIED: if (bus.qreqn_i) w_next = RUN;
      default: w_next = RUN;
    endcase
  end
  assign bus.rd_payload_o = w_rd_payload;
  assign bus.rd_empty_o = w_empty;
  assign bus.wr_full_o = w_full;
  assign bus.wr_flush_o = (r_state == FLUSH) ? ~r_done_q : '0;
  assign bus.qacceptn_o = r_state != STOPPED;
  assign bus.qdeny_o = r_state == DENIED;
  assign bus.qactive_o = (r_state == DENIED) ? 1'b1 :
                         (r_state == STOPPED) ? bus.if_wakeup_i : (w_any || bus.if_wakeup_i);
endmodule

// File: tb/tb_qchan_lp_buffer.sv
// tb_qchan_lp_buffer: vector table, corner sequences and randomized model check of qchan_lp_buffer
module tb_qchan_lp_buffer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  qchan_lp_buffer_if #(.DATA_W(8), .N_CH(2)) a_if ();
  qchan_lp_buffer_if #(.DATA_W(8), .N_CH(1)) b_if ();
  qchan_lp_buffer #(.DATA_W(8), .DEPTH(4), .N_CH(2)) dut_a (.clk(clk), .reset(reset), .bus(a_if.slave));
  qchan_lp_buffer #(.DATA_W(8), .DEPTH(3), .N_CH(1)) dut_b (.clk(clk), .reset(reset), .bus(b_if.slave));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a_if.if_wakeup_i = 1'b0;
    a_if.wr_valid_i = '0;
    a_if.wr_payload_i = '0;
    a_if.wr_done_i = '0;
    a_if.rd_valid_i = '0;
    a_if.qreqn_i = 1'b1;
  endtask

  task automatic drive_b(input logic wv, input logic [7:0] wd, input logic rv);
    b_if.wr_valid_i = wv;
    b_if.wr_payload_i = wd;
    b_if.rd_valid_i = rv;
  endtask

  typedef struct {
    logic [1:0] wv; logic [7:0] wd; logic [1:0] rv; logic qn; logic wk; logic [1:0] dn;
    logic [1:0] e_full; logic [1:0] e_empty; logic [1:0] e_flush;
    logic e_acc; logic e_deny; logic e_act; logic [7:0] e_head;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] wv, input logic [7:0] wd, input logic [1:0] rv,
                              input logic qn, input logic wk, input logic [1:0] dn,
                              input logic [1:0] ef, input logic [1:0] ee, input logic [1:0] efl,
                              input logic ea, input logic ed, input logic eact, input logic [7:0] eh);
    vec_t v;
    v.wv = wv; v.wd = wd; v.rv = rv; v.qn = qn; v.wk = wk; v.dn = dn;
    v.e_full = ef; v.e_empty = ee; v.e_flush = efl;
    v.e_acc = ea; v.e_deny = ed; v.e_act = eact; v.e_head = eh;
    return v;
  endfunction

  vec_t tv[32];

  localparam int M_RUN = 0, M_FLUSH = 1, M_DRAIN = 2, M_STOP = 3, M_DENY = 4;
  logic [7:0] mq[2][$];
  int ms;
  logic [1:0] md;

  initial begin
    //         wv  wd     rv qn wk dn   full empty flush acc deny act head
    tv[0]  = mk(0, 8'h00, 0, 1, 0, 0,   0, 3, 0, 1, 0, 0, 8'h00);
    tv[1]  = mk(1, 8'hA1, 0, 1, 0, 0,   0, 3, 0, 1, 0, 0, 8'h00);
    tv[2]  = mk(1, 8'hA2, 0, 1, 0, 0,   0, 2, 0, 1, 0, 1, 8'hA1);
    tv[3]  = mk(1, 8'hA3, 0, 1, 0, 0,   0, 2, 0, 1, 0, 1, 8'hA1);
    tv[4]  = mk(1, 8'hA4, 0, 1, 0, 0,   0, 2, 0, 1, 0, 1, 8'hA1);
    tv[5]  = mk(1, 8'hA5, 0, 1, 0, 0,   1, 2, 0, 1, 0, 1, 8'hA1);
    tv[6]  = mk(0, 8'h00, 0, 1, 0, 0,   1, 2, 0, 1, 0, 1, 8'hA1);
    tv[7]  = mk(0, 8'h00, 1, 1, 0, 0,   1, 2, 0, 1, 0, 1, 8'hA1);
    tv[8]  = mk(0, 8'h00, 1, 1, 0, 0,   0, 2, 0, 1, 0, 1, 8'hA2);
    tv[9]  = mk(0, 8'h00, 1, 1, 0, 0,   0, 2, 0, 1, 0, 1, 8'hA3);
    tv[10] = mk(0, 8'h00, 1, 1, 0, 0,   0, 2, 0, 1, 0, 1, 8'hA4);
    tv[11] = mk(0, 8'h00, 0, 1, 0, 0,   0, 3, 0, 1, 0, 0, 8'h00);
    tv[12] = mk(1, 8'hB1, 0, 1, 0, 0,   0, 3, 0, 1, 0, 0, 8'h00);
    tv[13] = mk(1, 8'hB2, 0, 1, 0, 0,   0, 2, 0, 1, 0, 1, 8'hB1);
    tv[14] = mk(0, 8'h00, 0, 0, 0, 0,   0, 2, 0, 1, 0, 1, 8'hB1);
    tv[15] = mk(0, 8'h00, 0, 0, 0, 1,   0, 2, 3, 1, 0, 1, 8'hB1);
    tv[16] = mk(0, 8'h00, 0, 0, 0, 2,   0, 2, 2, 1, 0, 1, 8'hB1);
    tv[17] = mk(1, 8'hC1, 1, 0, 0, 0,   0, 2, 0, 1, 0, 1, 8'hB1);
    tv[18] = mk(0, 8'h00, 1, 0, 0, 0,   0, 2, 0, 1, 0, 1, 8'hB2);
    tv[19] = mk(0, 8'h00, 0, 0, 0, 0,   0, 3, 0, 1, 0, 0, 8'h00);
    tv[20] = mk(0, 8'h00, 0, 0, 0, 0,   0, 3, 0, 0, 0, 0, 8'h00);
    tv[21] = mk(0, 8'h00, 0, 0, 1, 0,   0, 3, 0, 0, 0, 1, 8'h00);
    tv[22] = mk(1, 8'hD1, 0, 0, 1, 0,   0, 3, 0, 0, 0, 1, 8'h00);
    tv[23] = mk(0, 8'h00, 0, 1, 0, 0,   0, 3, 0, 0, 0, 0, 8'h00);
    tv[24] = mk(0, 8'h00, 0, 1, 0, 0,   0, 3, 0, 1, 0, 0, 8'h00);
    tv[25] = mk(1, 8'hE1, 0, 1, 0, 0,   0, 3, 0, 1, 0, 0, 8'h00);
    tv[26] = mk(0, 8'h00, 0, 0, 0, 0,   0, 2, 0, 1, 0, 1, 8'hE1);
    tv[27] = mk(0, 8'h00, 0, 0, 0, 3,   0, 2, 3, 1, 0, 1, 8'hE1);
    tv[28] = mk(0, 8'h00, 0, 0, 1, 0,   0, 2, 0, 1, 0, 1, 8'hE1);
    tv[29] = mk(1, 8'hF1, 1, 0, 0, 0,   0, 2, 0, 1, 1, 1, 8'hE1);
    tv[30] = mk(0, 8'h00, 0, 1, 0, 0,   0, 3, 0, 1, 1, 1, 8'h00);
    tv[31] = mk(0, 8'h00, 0, 1, 0, 0,   0, 3, 0, 1, 0, 0, 8'h00);

    idle_a();
    drive_b(0, 8'h00, 0);
    b_if.if_wakeup_i = 1'b0;
    b_if.wr_done_i = '0;
    b_if.qreqn_i = 1'b1;

    // reset state, with qactive following the wakeup input during reset
    a_if.if_wakeup_i = 1'b1;
    #12;
    chk("rst_empty", a_if.rd_empty_o, 2'b11);
    chk("rst_full", a_if.wr_full_o, 2'b00);
    chk("rst_flush", a_if.wr_flush_o, 2'b00);
    chk("rst_acc", a_if.qacceptn_o, 1'b1);
    chk("rst_deny", a_if.qdeny_o, 1'b0);
    chk("rst_act_wk", a_if.qactive_o, 1'b1);
    a_if.if_wakeup_i = 1'b0;
    #1;
    chk("rst_act", a_if.qactive_o, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // table: fill/drain, flush handshake, stop, wakeup-in-stop, deny path
    for (int i = 0; i < 32; i++) begin
      a_if.wr_valid_i = tv[i].wv;
      a_if.wr_payload_i = {8'h00, tv[i].wd};
      a_if.rd_valid_i = tv[i].rv;
      a_if.qreqn_i = tv[i].qn;
      a_if.if_wakeup_i = tv[i].wk;
      a_if.wr_done_i = tv[i].dn;
      #1;
      chk($sformatf("v%0d_full", i), a_if.wr_full_o, tv[i].e_full);
      chk($sformatf("v%0d_empty", i), a_if.rd_empty_o, tv[i].e_empty);
      chk($sformatf("v%0d_flush", i), a_if.wr_flush_o, tv[i].e_flush);
      chk($sformatf("v%0d_acc", i), a_if.qacceptn_o, tv[i].e_acc);
      chk($sformatf("v%0d_deny", i), a_if.qdeny_o, tv[i].e_deny);
      chk($sformatf("v%0d_act", i), a_if.qactive_o, tv[i].e_act);
      if (!tv[i].e_empty[0]) chk($sformatf("v%0d_head", i), a_if.rd_payload_o[7:0], tv[i].e_head);
      tick();
    end
    idle_a();

    // DEPTH=3: simultaneous push/pop on a full channel wraps the tail
    drive_b(1, 8'h11, 0); tick();
    drive_b(1, 8'h22, 0); tick();
    drive_b(1, 8'h33, 0); tick();
    drive_b(1, 8'h44, 0); #1;
    chk("b_full3", b_if.wr_full_o, 1'b1);
    tick();
    drive_b(1, 8'h55, 1); #1;
    chk("b_head_pre", b_if.rd_payload_o, 8'h11);
    tick();
    drive_b(0, 8'h00, 1); #1;
    chk("b_full_keep", b_if.wr_full_o, 1'b1);
    chk("b_head22", b_if.rd_payload_o, 8'h22);
    tick();
    #1;
    chk("b_not_full", b_if.wr_full_o, 1'b0);
    chk("b_head33", b_if.rd_payload_o, 8'h33);
    tick();
    #1;
    chk("b_tail55", b_if.rd_payload_o, 8'h55);
    tick();
    drive_b(1, 8'h66, 1); #1;
    chk("b_empty", b_if.rd_empty_o, 1'b1);
    tick();
    drive_b(0, 8'h00, 0); #1;
    chk("b_push_on_empty", b_if.rd_empty_o, 1'b0);
    chk("b_head66", b_if.rd_payload_o, 8'h66);

    // reset pulse mid-FLUSH with data on both channels
    a_if.wr_valid_i = 2'b11;
    a_if.wr_payload_i = 16'h2C1C;
    tick();
    a_if.wr_valid_i = 2'b00;
    a_if.qreqn_i = 1'b0;
    tick();
    #1;
    chk("r_flush_on", a_if.wr_flush_o, 2'b11);
    chk("r_data", a_if.rd_empty_o, 2'b00);
    #1;
    reset = 1'b1;
    #1;
    chk("r_empty", a_if.rd_empty_o, 2'b11);
    chk("r_flush_off", a_if.wr_flush_o, 2'b00);
    chk("r_acc", a_if.qacceptn_o, 1'b1);
    chk("r_deny", a_if.qdeny_o, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("r_run_flush", a_if.wr_flush_o, 2'b00);
    tick();
    chk("r_run_to_flush", a_if.wr_flush_o, 2'b11);
    chk("r_still_empty", a_if.rd_empty_o, 2'b11);

    // randomized run against a queue-based behavioural model
    idle_a();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    mq[0].delete();
    mq[1].delete();
    ms = M_RUN;
    md = 2'b00;
    tick();
    for (int n = 0; n < 1500; n++) begin
      logic [1:0] ef, ee, efl;
      logic e_acc, e_deny, e_act, pen, qen;
      logic [1:0] pu, po;
      int ns;
      logic [1:0] nd;
      if ($urandom_range(0, 7) == 0) a_if.qreqn_i = !a_if.qreqn_i;
      a_if.if_wakeup_i = $urandom_range(0, 9) == 0;
      a_if.wr_valid_i = 2'($urandom);
      a_if.wr_payload_i = 16'($urandom);
      a_if.rd_valid_i = 2'($urandom_range(0, 3) & ($urandom_range(0, 4) != 0 ? 2'b11 : 2'b00));
      a_if.wr_done_i = {$urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0};
      #1;
      for (int c = 0; c < 2; c++) begin
        ef[c] = mq[c].size() == 4;
        ee[c] = mq[c].size() == 0;
      end
      efl = (ms == M_FLUSH) ? ~md : 2'b00;
      e_acc = ms != M_STOP;
      e_deny = ms == M_DENY;
      e_act = (ms == M_DENY) || a_if.if_wakeup_i || (ms != M_STOP && ee != 2'b11);
      chk("rnd_full", a_if.wr_full_o, ef);
      chk("rnd_empty", a_if.rd_empty_o, ee);
      chk("rnd_flush", a_if.wr_flush_o, efl);
      chk("rnd_acc", a_if.qacceptn_o, e_acc);
      chk("rnd_deny", a_if.qdeny_o, e_deny);
      chk("rnd_act", a_if.qactive_o, e_act);
      for (int c = 0; c < 2; c++)
        if (!ee[c]) chk($sformatf("rnd_head%0d", c), a_if.rd_payload_o[c*8 +: 8], mq[c][0]);
      pen = ms == M_RUN || ms == M_FLUSH;
      qen = ms != M_STOP;
      for (int c = 0; c < 2; c++) begin
        po[c] = a_if.rd_valid_i[c] && qen && mq[c].size() > 0;
        pu[c] = a_if.wr_valid_i[c] && pen && (mq[c].size() < 4 || po[c]);
      end
      ns = ms;
      nd = md;
      if (ms == M_RUN && !a_if.qreqn_i) begin
        ns = M_FLUSH;
        nd = 2'b00;
      end else if (ms == M_FLUSH) begin
        nd = md | a_if.wr_done_i;
        if (a_if.if_wakeup_i) ns = M_DENY;
        else if (nd == 2'b11) ns = M_DRAIN;
      end else if (ms == M_DRAIN) begin
        if (a_if.if_wakeup_i) ns = M_DENY;
        else if (ee == 2'b11) ns = M_STOP;
      end else if ((ms == M_STOP || ms == M_DENY) && a_if.qreqn_i) begin
        ns = M_RUN;
      end
      for (int c = 0; c < 2; c++) begin
        if (po[c]) void'(mq[c].pop_front());
        if (pu[c]) mq[c].push_back(a_if.wr_payload_i[c*8 +: 8]);
      end
      ms = ns;
      md = nd;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
